shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//  Sequencer for a WIDTH-bit shift register with its register held internally.
//  Accepts a parallel load plus shift mode on start, then performs exactly WIDTH
//  shift steps, presenting the outgoing bit on ser_out and pulsing done at the end.
//  Sits between control logic and serial links as a PISO/SIPO engine with rotate.
// PARAMETERS
//  WIDTH   4   register width in bits; legal range WIDTH >= 2
// PORTS
//  clk       in   1              system clock; all state updates on posedge clk
//  rst       in   1              synchronous, active-high reset
//  start     in   1              request: load din_par and begin sequence (IDLE only)
//  dir       in   1              0 = shift toward MSB (q[0]->q[WIDTH-1]); 1 = toward LSB
//  rotate    in   1              1 = fill with bit shifted out; 0 = fill with ser_in
//  din_par   in   WIDTH          parallel load value
//  ser_in    in   1              serial fill bit, sampled each shift step
//  shift_en  in   1              1 = perform step this cycle; 0 = hold (stall)
//  q         out  WIDTH          register contents (registered)
//  ser_out   out  1              bit leaving on next step: q[WIDTH-1] if dir=0, q[0] if dir=1
//  busy      out  1              high in SHIFT state
//  done      out  1              one-cycle pulse in DONE state
//  cnt       out  $clog2(WIDTH+1) steps completed in current sequence
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, q=0, cnt=0, busy=0, done=0, latched dir/rotate=0.
//    Reset overrides all inputs; reset mid-sequence aborts with no done pulse.
//  - States: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: start=1 at edge k -> q<=din_par, cnt<=0, latch dir/rotate, go SHIFT.
//    start=0 -> q holds.
//  - SHIFT: shift_en=1 -> one step, cnt<=cnt+1; step taking cnt to WIDTH -> DONE.
//    shift_en=0 -> q, cnt, state hold. start, dir, rotate, din_par ignored.
//  - Step, dir=0: q<={q[WIDTH-2:0], f}, f = rotate ? q[WIDTH-1] : ser_in.
//    Step, dir=1: q<={f, q[WIDTH-1:1]}, f = rotate ? q[0] : ser_in.
//  - DONE: done=1, busy=0, q holds final value; next edge -> IDLE. start here ignored.
//  - Latency, no stalls: load at edge k, steps at k+1..k+WIDTH, done high for the
//    cycle after k+WIDTH, IDLE after k+WIDTH+1. Each stall cycle adds one.
//  - ser_out is combinational from q and latched dir (dir input in IDLE).
//  - cnt never exceeds WIDTH; returns to 0 only on next load or reset.
//  - Rotate with WIDTH steps leaves q equal to din_par.
// TESTING (WIDTH=4)
//  1 rst=1 two cycles, random inputs -> q=0000, busy=0, done=0, cnt=0.
//  2 start, din=1011, dir=0, rotate=0, ser_in=0 -> q 1011,0110,1100,1000,0000;
//    ser_out 1,0,1,1 before each step; done high one cycle, 5 cycles after start.
//  3 start, din=0001, dir=1, rotate=1 -> q 1000,0100,0010,0001; ser_out 1,0,0,0.
//  4 start, din=0000, dir=0, rotate=0, ser_in=1 -> q 0001,0011,0111,1111.
//  5 case 2 with shift_en=0 two cycles after first step -> q holds 0110, cnt holds 1,
//    done delayed by exactly 2 cycles, final q=0000.
//  6 start re-asserted during SHIFT -> no reload; rst after 2 steps -> IDLE, q=0000,
//    no done; fresh start afterwards runs normally.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequencer for an internal WIDTH-bit shift register.
// A start in IDLE loads the register and latches direction and rotate mode.
// The block then performs exactly WIDTH shift steps, stalling whenever
// shift_en is low, and pulses done for one cycle before returning to IDLE.
module shift_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       dir,
  input  logic                       rotate,
  input  logic [WIDTH-1:0]           din_par,
  input  logic                       ser_in,
  input  logic                       shift_en,
  output logic [WIDTH-1:0]           q,
  output logic                       ser_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic             dir_l;
  logic             rot_l;
  logic             fill;
  logic [WIDTH-1:0] q_next;

  // Next register value for one step, using the mode latched at load time
  always_comb begin
    fill   = ser_in;
    q_next = q;
    if (rot_l) begin
      fill = dir_l ? q[0] : q[WIDTH-1];
    end
    if (dir_l) begin
      q_next = {fill, q[WIDTH-1:1]};
    end else begin
      q_next = {q[WIDTH-2:0], fill};
    end
  end

  // Outgoing bit and status flags; in IDLE the live dir input selects the end
  always_comb begin
    ser_out = ((state == S_IDLE) ? dir : dir_l) ? q[0] : q[WIDTH-1];
    busy    = (state == S_SHIFT);
    done    = (state == S_DONE);
  end

  // Sequencer state, register contents, step counter and latched mode
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      cnt   <= '0;
      dir_l <= 1'b0;
      rot_l <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            q     <= din_par;
            cnt   <= '0;
            dir_l <= dir;
            rot_l <= rotate;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (shift_en) begin
            q   <= q_next;
            cnt <= cnt + CW'(1);
            if (cnt == LAST_STEP) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed bench for shift_seq_ctrl (WIDTH=4) with a
// behavioural reference model compared every cycle plus literal spot checks.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dir;
  logic       rotate;
  logic [3:0] din_par;
  logic       ser_in;
  logic       shift_en;
  logic [3:0] q;
  logic       ser_out;
  logic       busy;
  logic       done;
  logic [2:0] cnt;

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .rotate   (rotate),
    .din_par  (din_par),
    .ser_in   (ser_in),
    .shift_en (shift_en),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase 0 idle, 1 shifting, 2 done; register kept as an integer
  int m_phase = 0;
  int m_q     = 0;
  int m_steps = 0;
  int m_dir   = 0;
  int m_rot   = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    int f;
    if (rst) begin
      m_phase = 0;
      m_q = 0;
      m_steps = 0;
      m_dir = 0;
      m_rot = 0;
      model_valid = 1'b1;
    end else if (m_phase == 0) begin
      if (start) begin
        m_q = int'(din_par);
        m_steps = 0;
        m_dir = int'(dir);
        m_rot = int'(rotate);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (shift_en) begin
        if (m_dir == 0) begin
          f = (m_rot != 0) ? (m_q / 8) % 2 : int'(ser_in);
          m_q = (m_q * 2 + f) % 16;
        end else begin
          f = (m_rot != 0) ? m_q % 2 : int'(ser_in);
          m_q = m_q / 2 + f * 8;
        end
        m_steps = m_steps + 1;
        if (m_steps == WIDTH) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge clk) begin
    int exp_dir;
    if (model_valid) begin
      exp_dir = (m_phase == 0) ? int'(dir) : m_dir;
      checkOutput("model_q", int'(q), m_q);
      checkOutput("model_cnt", int'(cnt), m_steps);
      checkOutput("model_busy", int'(busy), (m_phase == 1) ? 1 : 0);
      checkOutput("model_done", int'(done), (m_phase == 2) ? 1 : 0);
      checkOutput("model_ser_out", int'(ser_out), (exp_dir != 0) ? m_q % 2 : (m_q / 8) % 2);
    end
  end

  task automatic applyStimulus(input logic st, input logic d, input logic ro,
                               input logic [3:0] dp, input logic si,
                               input logic en, input logic rs);
    start    = st;
    dir      = d;
    rotate   = ro;
    din_par  = dp;
    ser_in   = si;
    shift_en = en;
    rst      = rs;
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp2 [4] = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
  logic       so2  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [3:0] exp3 [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic       so3  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] exp4 [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  // Global watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    start = 0; dir = 0; rotate = 0; din_par = 0; ser_in = 0; shift_en = 0; rst = 1;

    // 1: reset for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom), 1'b1);
    end
    checkOutput("reset_q", int'(q), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_cnt", int'(cnt), 0);
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);

    // 2: PISO shift toward MSB with zero fill
    applyStimulus(1, 0, 0, 4'b1011, 0, 1, 0);
    checkOutput("t2_load_q", int'(q), 11);
    checkOutput("t2_load_busy", int'(busy), 1);
    checkOutput("t2_load_ser_out", int'(ser_out), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
      checkOutput("t2_q", int'(q), int'(exp2[i]));
      checkOutput("t2_done", int'(done), (i == 3) ? 1 : 0);
      if (i < 3) checkOutput("t2_ser_out", int'(ser_out), int'(so2[i]));
    end
    applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("t2_done_drop", int'(done), 0);
    checkOutput("t2_idle_busy", int'(busy), 0);
    checkOutput("t2_hold_q", int'(q), 0);
    checkOutput("t2_hold_cnt", int'(cnt), 4);

    // 3: rotate toward LSB returns to the loaded value
    applyStimulus(1, 1, 1, 4'b0001, 0, 1, 0);
    checkOutput("t3_load_ser_out", int'(ser_out), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'b1111, 0, 1, 0);
      checkOutput("t3_q", int'(q), int'(exp3[i]));
      checkOutput("t3_ser_out", int'(ser_out), int'(so3[i]));
    end
    checkOutput("t3_done", int'(done), 1);
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);

    // 4: SIPO fill with ones toward MSB
    applyStimulus(1, 0, 0, 4'b0000, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 4'b0000, 1, 1, 0);
      checkOutput("t4_q", int'(q), int'(exp4[i]));
    end
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);

    // 5: case 2 with a two-cycle stall after the first step
    applyStimulus(1, 0, 0, 4'b1011, 0, 1, 0);
    edges = 0;
    applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
    edges++;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);
      edges++;
      checkOutput("t5_stall_q", int'(q), 6);
      checkOutput("t5_stall_cnt", int'(cnt), 1);
      checkOutput("t5_stall_busy", int'(busy), 1);
    end
    while (done !== 1'b1 && edges < 20) begin
      applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
      edges++;
    end
    checkOutput("t5_done_latency", edges, 6);
    checkOutput("t5_final_q", int'(q), 0);
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);

    // 6: start ignored while shifting, reset aborts, fresh run afterwards
    applyStimulus(1, 0, 0, 4'b1011, 0, 1, 0);
    applyStimulus(1, 1, 1, 4'b1111, 0, 1, 0);
    checkOutput("t6_no_reload_q", int'(q), 6);
    applyStimulus(1, 1, 1, 4'b1111, 0, 1, 0);
    checkOutput("t6_step2_q", int'(q), 12);
    applyStimulus(0, 0, 0, 4'b0000, 0, 1, 1);
    checkOutput("t6_abort_q", int'(q), 0);
    checkOutput("t6_abort_busy", int'(busy), 0);
    checkOutput("t6_abort_cnt", int'(cnt), 0);
    applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
    checkOutput("t6_abort_no_done", int'(done), 0);
    applyStimulus(1, 1, 1, 4'b0001, 0, 1, 0);
    edges = 0;
    while (done !== 1'b1 && edges < 20) begin
      applyStimulus(0, 0, 0, 4'b0000, 0, 1, 0);
      edges++;
    end
    checkOutput("t6_fresh_latency", edges, 4);
    checkOutput("t6_fresh_q", int'(q), 1);
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 4'b0000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
